noc_buf_ctrl: RTL and testbench

- Synchronous FIFO controller that drives an external dual-port buffer RAM. The RAM has a level-sensitive asynchronous write on port 0 and an asynchronous read on port 1.
- Input side: accepts flits from the upstream link through a valid/ready handshake and writes them to the RAM.
- Output side: reads flits back in arrival order through a registered output stage, with valid/ready to the downstream router stage.
- Provides the clocked pointers, occupancy tracking and glitch-free RAM strobes that the asynchronous RAM lacks.

---
 rtl/noc_buf_ctrl.sv | 139 +++++++++++++
 tb/tb_noc_buf_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_buf_ctrl.sv
// noc_buf_ctrl: synchronous FIFO controller for an external dual-port buffer RAM.
// The RAM writes asynchronously (level-sensitive) on port 0 and reads
// asynchronously on port 1. This block supplies the clocked pointers, the
// occupancy count and flop-driven, glitch-free RAM strobes. A registered
// output stage holds one flit in addition to the RAM contents.
module noc_buf_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3,
  parameter int RAM_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // upstream link
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  // downstream router stage
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  // RAM port 0 (write)
  output logic [ADDR_WIDTH-1:0] ram_address_0,
  output logic [DATA_WIDTH-1:0] ram_data_0,
  output logic                  ram_cs_0,
  output logic                  ram_we_0,
  // RAM port 1 (read)
  output logic [ADDR_WIDTH-1:0] ram_address_1,
  input  logic [DATA_WIDTH-1:0] ram_data_1,
  output logic                  ram_cs_1,
  output logic                  ram_we_1,
  output logic                  ram_oe_1,
  // status
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [CW-1:0]         cnt_t;

  // Pointer advance with wrap at RAM_DEPTH, so non-power-of-2 depths work.
  function automatic addr_t ptr_inc(input addr_t p);
    return (p == addr_t'(RAM_DEPTH - 1)) ? '0 : p + addr_t'(1);
  endfunction

  addr_t wptr_q, wptr_d;
  addr_t rptr_q, rptr_d;
  cnt_t  count_q, count_d;
  logic  wr_stb_q, wr_stb_d;
  addr_t wr_addr_q, wr_addr_d;
  data_t wr_data_q, wr_data_d;
  logic  out_valid_q, out_valid_d;
  data_t out_data_q, out_data_d;

  logic  push;
  logic  load;
  cnt_t  avail;

  // An entry is readable only once its write strobe has completed, so the
  // pending write (if any) is subtracted from the occupancy.
  assign avail    = count_q - cnt_t'(wr_stb_q);
  assign full     = (count_q == cnt_t'(RAM_DEPTH));
  assign in_ready = !full;
  assign empty    = (count_q == '0) && !out_valid_q;
  assign count    = count_q;

  assign push = in_valid && in_ready;
  assign load = (avail != '0) && (!out_valid_q || out_ready);

  // Write port straight from flops: strobe, address and data change only at edges.
  assign ram_address_0 = wr_addr_q;
  assign ram_data_0    = wr_data_q;
  assign ram_cs_0      = wr_stb_q;
  assign ram_we_0      = wr_stb_q;

  // Read port: the pending-write address never equals rptr while avail != 0.
  assign ram_address_1 = rptr_q;
  assign ram_cs_1      = (avail != '0);
  assign ram_oe_1      = (avail != '0);
  assign ram_we_1      = 1'b0;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  // Next-state for pointers, write staging, output stage and occupancy.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_stb_d    = push;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    count_d     = count_q + cnt_t'(push) - cnt_t'(load);

    if (push) begin
      wr_addr_d = wptr_q;
      wr_data_d = in_data;
      wptr_d    = ptr_inc(wptr_q);
    end

    if (load) begin
      out_data_d  = ram_data_1;
      out_valid_d = 1'b1;
      rptr_d      = ptr_inc(rptr_q);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset also kills a pending write strobe.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_noc_buf_ctrl.sv
// tb_noc_buf_ctrl: directed bench for noc_buf_ctrl with a behavioural model
// of the asynchronous dual-port buffer RAM.
module tb_noc_buf_ctrl;

  localparam int DW = 12;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] ram_address_0;
  logic [DW-1:0] ram_data_0;
  logic          ram_cs_0;
  logic          ram_we_0;
  logic [AW-1:0] ram_address_1;
  logic [DW-1:0] ram_data_1;
  logic          ram_cs_1;
  logic          ram_we_1;
  logic          ram_oe_1;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  int n_vec = 0;
  int n_err = 0;
  int nxt;
  logic acc;

  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  noc_buf_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ram_address_0(ram_address_0), .ram_data_0(ram_data_0),
    .ram_cs_0(ram_cs_0), .ram_we_0(ram_we_0),
    .ram_address_1(ram_address_1), .ram_data_1(ram_data_1),
    .ram_cs_1(ram_cs_1), .ram_we_1(ram_we_1), .ram_oe_1(ram_oe_1),
    .count(count), .full(full), .empty(empty)
  );

  // RAM model: the write strobe spans a whole cycle with stable address/data,
  // so committing at mid-cycle is equivalent to a level-sensitive write.
  always @(negedge clk) begin
    if (ram_cs_0 && ram_we_0) mem[ram_address_0] <= ram_data_0;
  end
  assign ram_data_1 = mem[ram_address_1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] f5(input int k);
    return DW'(12'h500 + k);
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // 1: reset
    tick; tick;
    rst = 1'b0;
    check("rst in_ready",  32'(in_ready), 1);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst empty",     32'(empty), 1);
    check("rst full",      32'(full), 0);
    check("rst count",     32'(count), 0);
    check("rst cs0",       32'(ram_cs_0), 0);
    check("rst we0",       32'(ram_we_0), 0);
    check("rst cs1",       32'(ram_cs_1), 0);
    check("rst oe1",       32'(ram_oe_1), 0);
    check("rst we1",       32'(ram_we_1), 0);

    // 2: single flit, latency 2
    out_ready = 1'b1; in_data = 12'hA5C; in_valid = 1'b1;
    tick;                                   // edge 0: push
    in_valid = 1'b0;
    check("t2 cs0 e0",   32'(ram_cs_0), 1);
    check("t2 we0 e0",   32'(ram_we_0), 1);
    check("t2 addr0",    32'(ram_address_0), 0);
    check("t2 data0",    32'(ram_data_0), 32'h0A5C);
    check("t2 count e0", 32'(count), 1);
    check("t2 cs1 e0",   32'(ram_cs_1), 0);
    check("t2 valid e0", 32'(out_valid), 0);
    tick;                                   // edge 1: strobe ends
    check("t2 cs0 e1",   32'(ram_cs_0), 0);
    check("t2 cs1 e1",   32'(ram_cs_1), 1);
    check("t2 valid e1", 32'(out_valid), 0);
    tick;                                   // edge 2: load
    check("t2 valid e2", 32'(out_valid), 1);
    check("t2 data e2",  32'(out_data), 32'h0A5C);
    check("t2 count e2", 32'(count), 0);
    check("t2 empty e2", 32'(empty), 0);
    tick;                                   // edge 3: taken
    check("t2 valid e3", 32'(out_valid), 0);
    check("t2 empty e3", 32'(empty), 1);

    // 3: fill with out_ready low, then drain
    out_ready = 1'b0; nxt = 1;
    for (int c = 0; c < 14; c++) begin
      in_valid = (nxt <= 12);
      in_data  = DW'(nxt);
      acc = in_valid && in_ready;
      tick;
      if (acc) nxt++;
    end
    in_valid = 1'b0;
    check("t3 accepted", 32'(nxt - 1), 9);
    check("t3 count",    32'(count), 8);
    check("t3 full",     32'(full), 1);
    check("t3 in_ready", 32'(in_ready), 0);
    check("t3 head",     32'(out_data), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("t3 drain valid", 32'(out_valid), 1);
      check("t3 drain data",  32'(out_data), 32'(i + 1));
      tick;
    end
    check("t3 end valid", 32'(out_valid), 0);
    check("t3 end count", 32'(count), 0);
    check("t3 end empty", 32'(empty), 1);

    // 4: streaming 20 flits, both sides always ready
    for (int c = 0; c < 24; c++) begin
      in_valid = (c < 20);
      in_data  = DW'(c + 1);
      tick;                                 // edge c
      check("t4 valid", 32'(out_valid), 32'(c >= 2 && c <= 21));
      if (c >= 2 && c <= 21) check("t4 data", 32'(out_data), 32'(c - 1));
      check("t4 count le2", 32'(count <= 2), 1);
    end
    in_valid = 1'b0;
    check("t4 end empty", 32'(empty), 1);

    // 5: preload 6 (5 in RAM + 1 in output reg), push+pop 4 cycles, then hold
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      in_valid = 1'b1; in_data = f5(k);
      tick;                                 // edges 0..5
    end
    check("t5 pre count", 32'(count), 5);
    check("t5 pre data",  32'(out_data), 32'(f5(1)));
    out_ready = 1'b1;
    for (int k = 7; k <= 10; k++) begin
      in_data = f5(k);
      tick;                                 // edges 6..9
      check("t5 both count", 32'(count), 5);
      check("t5 both data",  32'(out_data), 32'(f5(k - 5)));
    end
    in_valid = 1'b0;
    out_ready = 1'b1; tick;                 // edge 10: load 6
    check("t5 r1 data",  32'(out_data), 32'(f5(6)));
    check("t5 r1 count", 32'(count), 4);
    out_ready = 1'b0; tick;                 // edge 11: hold
    check("t5 h1 data",  32'(out_data), 32'(f5(6)));
    check("t5 h1 valid", 32'(out_valid), 1);
    tick;                                   // edge 12: hold
    check("t5 h2 data",  32'(out_data), 32'(f5(6)));
    check("t5 h2 count", 32'(count), 4);
    out_ready = 1'b1; tick;                 // edge 13: load 7
    check("t5 r2 data",  32'(out_data), 32'(f5(7)));
    check("t5 r2 count", 32'(count), 3);
    for (int k = 8; k <= 10; k++) begin
      tick;
      check("t5 drain data", 32'(out_data), 32'(f5(k)));
    end
    tick;
    check("t5 end valid", 32'(out_valid), 0);
    check("t5 end empty", 32'(empty), 1);

    // 6: reset during a write strobe
    in_data = 12'h3C3; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("t6 stb pre", 32'(ram_cs_0), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t6 cs0",   32'(ram_cs_0), 0);
    check("t6 count", 32'(count), 0);
    check("t6 valid", 32'(out_valid), 0);
    for (int c = 0; c < 4; c++) begin
      tick;
      check("t6 no out", 32'(out_valid), 0);
      check("t6 no rd",  32'(ram_cs_1), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
